inv_cipher: RTL and testbench

Iterative AES decryptor (FIPS-197 InvCipher). It accepts one 128-bit ciphertext block and a fully expanded key schedule, and performs one inverse round per clock. It returns the plaintext with a one-cycle done pulse. It is the receive-side counterpart of the iterative encryptor and shares its key-schedule format and bit ordering.

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/inv_cipher_if.sv | 15 +
 rtl/inv_cipher_inv_round.sv | 33 +++
 rtl/inv_cipher.sv | 126 ++++++++++++
 tb/tb_inv_cipher.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: inverse S-box, GF(2^8) helpers, FSM encoding.
// The optional key latch is selected in the top with INV_CIPHER_KEY_LATCH_EN.
package aes_pkg;

    localparam int RK_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        FINAL  = 2'd2
    } fsm_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant built from the bits of c (x9, xB, xD, xE).
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        return {gf_mul(s0, 4'he) ^ gf_mul(s1, 4'hb) ^ gf_mul(s2, 4'hd) ^ gf_mul(s3, 4'h9),
                gf_mul(s0, 4'h9) ^ gf_mul(s1, 4'he) ^ gf_mul(s2, 4'hb) ^ gf_mul(s3, 4'hd),
                gf_mul(s0, 4'hd) ^ gf_mul(s1, 4'h9) ^ gf_mul(s2, 4'he) ^ gf_mul(s3, 4'hb),
                gf_mul(s0, 4'hb) ^ gf_mul(s1, 4'hd) ^ gf_mul(s2, 4'h9) ^ gf_mul(s3, 4'he)};
    endfunction

    function automatic logic [0:127] add_round_key(input logic [0:127] s, input logic [0:127] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/inv_cipher_if.sv
// Block/handshake bundle between an AES decryptor and its requester.
interface inv_cipher_if #(
    parameter int NK = 4,
    parameter int NR = NK + 6
);
    logic                     start;
    logic [0:127]             cipherText;
    logic [0:128*(NR+1)-1]    keys;
    logic [0:127]             plainText;
    logic                     busy;
    logic                     done;

    modport master (output start, cipherText, keys, input plainText, busy, done);
    modport slave  (input start, cipherText, keys, output plainText, busy, done);
endinterface

// File: rtl/inv_cipher_inv_round.sv
// One combinational inverse round; i_bypass_mix skips InvMixColumns for the last round.
import aes_pkg::*;

module inv_round (
    input  logic [0:127] i_state,
    input  logic [0:127] i_round_key,
    input  logic         i_bypass_mix,
    output logic [0:127] o_state
);
    logic [7:0]  w_byte [16];
    logic [31:0] w_col;

    // Byte (r,c) lives at index r+4c; row r is rotated right by r columns.
    always_comb begin
        w_byte  = '{default: 8'h00};
        w_col   = 32'h0000_0000;
        o_state = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_byte[r + 4*c] = INV_SBOX[i_state[8*(r + 4*((c - r + 4) % 4)) +: 8]]
                                  ^ i_round_key[8*(r + 4*c) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_col = {w_byte[4*c], w_byte[4*c+1], w_byte[4*c+2], w_byte[4*c+3]};
            if (i_bypass_mix) begin
                o_state[32*c +: 32] = w_col;
            end else begin
                o_state[32*c +: 32] = inv_mix_col(w_col);
            end
        end
    end
endmodule

// File: rtl/inv_cipher.sv
// Iterative AES InvCipher, one inverse round per clock.
// Define INV_CIPHER_KEY_LATCH_EN to capture the key schedule on start.
import aes_pkg::*;

module inv_cipher #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic         clks,
    input  logic         reset,
    inv_cipher_if.slave  bus
);
    localparam int KEY_W = RK_W * (Nr + 1);

    fsm_e             r_fsm;
    fsm_e             w_fsm_nxt;
    logic [3:0]       r_round;
    logic [0:127]     r_state;
    logic [0:127]     r_plain;
    logic             r_busy;
    logic             r_done;
    logic [0:KEY_W-1] w_keys;
    logic [0:127]     w_rkey;
    logic [0:127]     w_round_out;
    logic             w_accept;

    assign w_accept = (r_fsm == IDLE) && bus.start;

`ifdef INV_CIPHER_KEY_LATCH_EN
    logic [0:KEY_W-1] r_keys;

    // Private copy of the schedule so the requester may reuse the key bus while busy.
    always_ff @(posedge clks) begin
        if (reset) begin
            r_keys <= '0;
        end else if (w_accept) begin
            r_keys <= bus.keys;
        end
    end
    assign w_keys = r_keys;
`else
    assign w_keys = bus.keys;
`endif

    // r_round is already 0 in FINAL, so one selector serves both round kinds.
    assign w_rkey = w_keys[RK_W*int'(r_round) +: RK_W];

    inv_round u_round (
        .i_state      (r_state),
        .i_round_key  (w_rkey),
        .i_bypass_mix (r_fsm == FINAL),
        .o_state      (w_round_out)
    );

    // Controller state register.
    always_ff @(posedge clks) begin
        if (reset) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE: begin
                if (bus.start) begin
                    w_fsm_nxt = ROUNDS;
                end else begin
                    w_fsm_nxt = IDLE;
                end
            end
            ROUNDS: begin
                if (r_round == 4'd1) begin
                    w_fsm_nxt = FINAL;
                end else begin
                    w_fsm_nxt = ROUNDS;
                end
            end
            FINAL:   w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Datapath, round counter and registered outputs.
    always_ff @(posedge clks) begin
        if (reset) begin
            r_round <= 4'd0;
            r_state <= '0;
            r_plain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= add_round_key(bus.cipherText, bus.keys[RK_W*Nr +: RK_W]);
                        r_round <= 4'(Nr - 1);
                        r_busy  <= 1'b1;
                    end
                end
                ROUNDS: begin
                    r_state <= w_round_out;
                    r_round <= r_round - 4'd1;
                end
                FINAL: begin
                    r_plain <= w_round_out;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_round <= 4'd0;
                end
                default: begin
                    r_round <= 4'd0;
                end
            endcase
        end
    end

    assign bus.plainText = r_plain;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher at AES-128/192/256 with an expected-plaintext scoreboard.
module tb_inv_cipher;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_ALT = 128'hdeadbeef0123456789abcdeffedcba98;
`ifdef INV_CIPHER_KEY_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clks = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [127:0] sb_q [$];
    logic [0:128*15-1] ks4, ks6, ks8;

    always #5 clks = ~clks;

    inv_cipher_if #(.NK(4)) bus4 ();
    inv_cipher_if #(.NK(6)) bus6 ();
    inv_cipher_if #(.NK(8)) bus8 ();

    inv_cipher #(.Nk(4)) u4 (.clks(clks), .reset(reset), .bus(bus4));
    inv_cipher #(.Nk(6)) u6 (.clks(clks), .reset(reset), .bus(bus6));
    inv_cipher #(.Nk(8)) u8 (.clks(clks), .reset(reset), .bus(bus8));

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box from its definition: GF inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Key 00 01 02 ... expanded per FIPS-197 for nk words.
    function automatic logic [0:128*15-1] expand(input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        logic [0:128*15-1] ks = '0;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr+1); i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return bus4.done;
            1: return bus6.done;
            default: return bus8.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return bus4.busy;
            1: return bus6.busy;
            default: return bus8.busy;
        endcase
    endfunction

    function automatic logic [127:0] get_pt(input int sel);
        case (sel)
            0: return bus4.plainText;
            1: return bus6.plainText;
            default: return bus8.plainText;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs !== exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected anything but %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [127:0] ct);
        case (sel)
            0: begin bus4.start = st; bus4.cipherText = ct; end
            1: begin bus6.start = st; bus6.cipherText = ct; end
            default: begin bus8.start = st; bus8.cipherText = ct; end
        endcase
    endtask

    // Raise start for one edge; returns at the negedge after that edge.
    task automatic poke(input int sel, input logic [127:0] ct);
        drive(sel, 1'b1, ct);
        @(negedge clks);
        drive(sel, 1'b0, ct);
    endtask

    task automatic launch(input int sel, input logic [127:0] ct, input logic [127:0] exp_pt);
        sb_q.push_back(exp_pt);
        poke(sel, ct);
    endtask

    // lat counts edges after the start edge; done must appear at lat == nr.
    task automatic expect_done(input int sel, input int nr, input int lat0, input string tag,
                               input bit want_eq);
        int lat = lat0;
        logic [127:0] exp = '0;
        while (get_done(sel) !== 1'b1 && lat < 40) begin
            @(negedge clks);
            lat++;
        end
        check({tag, "_done"}, 128'(get_done(sel)), 128'd1);
        if (get_done(sel) === 1'b1) begin
            check({tag, "_latency"}, 128'(lat), 128'(nr));
            check({tag, "_busy"}, 128'(get_busy(sel)), 128'd0);
            check({tag, "_sb_depth"}, 128'(sb_q.size()), 128'd1);
            if (sb_q.size() != 0) exp = sb_q.pop_front();
            if (want_eq) check({tag, "_pt"}, get_pt(sel), exp);
            else check_ne({tag, "_pt"}, get_pt(sel), exp);
        end
    endtask

    task automatic no_done(input int sel, input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(negedge clks);
            if (get_done(sel) !== 1'b0) seen++;
        end
        check(tag, 128'(seen), 128'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 128'h0);
        ks4 = expand(4);
        ks6 = expand(6);
        ks8 = expand(8);
        bus4.keys = ks4[0:128*11-1];
        bus6.keys = ks6[0:128*13-1];
        bus8.keys = ks8;
        repeat (3) @(negedge clks);
        for (int s = 0; s < 3; s++) begin
            check("reset_pt", get_pt(s), 128'h0);
            check("reset_busy", 128'(get_busy(s)), 128'd0);
            check("reset_done", 128'(get_done(s)), 128'd0);
        end
        reset = 1'b0;
        @(negedge clks);

        launch(0, CT128, PT);
        check("c1_busy_inflight", 128'(get_busy(0)), 128'd1);
        expect_done(0, 10, 0, "c1", 1'b1);
        launch(1, CT192, PT);
        expect_done(1, 12, 0, "c2", 1'b1);
        launch(2, CT256, PT);
        expect_done(2, 14, 0, "c3", 1'b1);

        // Second start three cycles in is dropped; third start rides the done cycle.
        @(negedge clks);
        launch(0, CT128, PT);
        repeat (2) @(negedge clks);
        poke(0, CT_ALT);
        expect_done(0, 10, 3, "ignored", 1'b1);
        launch(0, CT128, PT);
        expect_done(0, 10, 0, "b2b", 1'b1);
        no_done(0, 15, "no_extra_done");

        // Reset while round counter holds 5.
        launch(0, CT128, PT);
        repeat (4) @(negedge clks);
        check("pre_reset_busy", 128'(get_busy(0)), 128'd1);
        reset = 1'b1;
        @(negedge clks);
        check("midrst_busy", 128'(get_busy(0)), 128'd0);
        check("midrst_done", 128'(get_done(0)), 128'd0);
        check("midrst_pt", get_pt(0), 128'h0);
        sb_q.delete();
        reset = 1'b0;
        no_done(0, 15, "midrst_no_done");
        launch(0, CT128, PT);
        expect_done(0, 10, 0, "after_rst", 1'b1);

        // Schedule zeroed one cycle after start.
        @(negedge clks);
        launch(0, CT128, PT);
        bus4.keys = '0;
        expect_done(0, 10, 0, "key_change", LATCH);
        bus4.keys = ks4[0:128*11-1];

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
